// File: rtl/mult_fu_bank_pkg.sv
// Shared multiply-unit definitions used by the issue FIFO consumer and the
// completion stage. This package has no ports. It provides:
//   MULT_OP            - multiply operation encoding
//   ISSUE_FU_PACKET    - one FIFO output slot as seen by a functional unit
//   FU_COMPLETE_PACKET - one finished result offered to the CDB stage
//   helper functions   - operand extension and result-half selection
package mult_fu_bank_pkg;

  localparam int MULT_STAGES_DEFAULT = 4;
  localparam int PR_W  = 6;
  localparam int ROB_W = 5;

  // The encoding is two bits wide, so every value names a real op.
  // Consumers still fall back to MUL in their default branches so that a
  // wider encoding later on keeps the same behaviour.
  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_OP;

  typedef struct packed {
    logic             valid;
    MULT_OP           op_sel;
    logic [31:0]      rs1_value;
    logic [31:0]      rs2_value;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic             valid;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
    logic [31:0]      result;
  } FU_COMPLETE_PACKET;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic rs1_is_signed(input MULT_OP op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic rs2_is_signed(input MULT_OP op);
    return (op == MULH);
  endfunction

  // MUL keeps the low word; every other op keeps the high word.
  function automatic logic returns_high(input MULT_OP op);
    return (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

  // Extending both operands to 64 bits lets one unsigned 64x64 product,
  // truncated to 64 bits, serve all signedness combinations.
  function automatic logic [63:0] extend_operand(input logic [31:0] value,
                                                 input logic        is_signed);
    return {{32{is_signed & value[31]}}, value};
  endfunction

endpackage

// File: rtl/mult_fu_bank_lane.sv
// mult_lane: one pipelined multiplier lane.
// The lane is a shift pipeline of MULT_STAGES registers. Each register adds
// one 64/MULT_STAGES-bit slice of the multiplier into the running product.
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-high clear
//   squash       in   synchronous flush of all in-flight ops
//   pckt_in      in   packet loaded into stage 0 whenever the lane advances
//   advance      in   shift every stage forward by one this cycle
//   complete_out out  last-stage result (all fields zero when invalid)
//   lane_empty   out  no stage holds a valid op
module mult_lane
  import mult_fu_bank_pkg::*;
#(
  parameter int MULT_STAGES = MULT_STAGES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  ISSUE_FU_PACKET    pckt_in,
  input  logic              advance,
  output FU_COMPLETE_PACKET complete_out,
  output logic              lane_empty
);

  localparam int SLICE_W = 64 / MULT_STAGES;
  localparam logic [63:0] SLICE_MASK =
    (SLICE_W >= 64) ? {64{1'b1}} : ((64'd1 << SLICE_W) - 64'd1);

  typedef struct packed {
    logic             valid;
    MULT_OP           op;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
    logic [63:0]      partial;
    logic [63:0]      mcand;
    logic [63:0]      mplier;
  } stage_t;

  stage_t stage_q [MULT_STAGES];
  stage_t next_q  [MULT_STAGES];
  stage_t entry_d;
  stage_t last_stage;

  // Fold the lowest remaining multiplier slice into the partial sum, then
  // move the multiplicand up and the multiplier down for the next slice.
  function automatic stage_t accumulate(input stage_t s);
    stage_t      r;
    logic [63:0] slice;
    r         = s;
    slice     = s.mplier & SLICE_MASK;
    r.partial = s.partial + s.mcand * slice;
    r.mcand   = s.mcand << SLICE_W;
    r.mplier  = s.mplier >> SLICE_W;
    return r;
  endfunction

  // A fresh op is extended here and gets its first slice on the way into
  // stage 0, so after MULT_STAGES registers all slices have been summed.
  always_comb begin
    entry_d           = '0;
    entry_d.valid     = pckt_in.valid;
    entry_d.op        = pckt_in.op_sel;
    entry_d.dest_pr   = pckt_in.dest_pr;
    entry_d.rob_entry = pckt_in.rob_entry;
    entry_d.mcand     = extend_operand(pckt_in.rs1_value, rs1_is_signed(pckt_in.op_sel));
    entry_d.mplier    = extend_operand(pckt_in.rs2_value, rs2_is_signed(pckt_in.op_sel));
    next_q[0]         = accumulate(entry_d);
    for (int k = 1; k < MULT_STAGES; k++) begin
      next_q[k] = accumulate(stage_q[k-1]);
    end
  end

  // Reset and squash both empty the lane. Otherwise the lane either shifts
  // as a whole or holds as a whole; bubbles are never collapsed.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int k = 0; k < MULT_STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < MULT_STAGES; k++) begin
        stage_q[k] <= next_q[k];
      end
    end
  end

  // Present the last stage, selecting the requested half of the product.
  always_comb begin
    last_stage   = stage_q[MULT_STAGES-1];
    complete_out = '0;
    if (last_stage.valid) begin
      complete_out.valid     = 1'b1;
      complete_out.dest_pr   = last_stage.dest_pr;
      complete_out.rob_entry = last_stage.rob_entry;
      complete_out.result    = returns_high(last_stage.op) ? last_stage.partial[63:32]
                                                           : last_stage.partial[31:0];
    end
  end

  // The lane is empty when no stage holds a valid op.
  always_comb begin
    lane_empty = 1'b1;
    for (int k = 0; k < MULT_STAGES; k++) begin
      if (stage_q[k].valid) begin
        lane_empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mult_fu_bank.sv
// mult_fu_bank: consumer end of the multiply issue FIFO.
// There are three independent pipelined multiplier lanes. Lane i pops FIFO
// slot i only when it can move, and holds a finished result until granted.
// Ports:
//   clock         in   system clock
//   reset         in   synchronous active-high clear of every lane
//   squash        in   mispredict flush of every lane
//   fu_pckt_in    in   FIFO output slots, slot i feeds lane i
//   rd_EN         out  lane i takes slot i at this posedge
//   complete_gnt  in   completion stage accepts lane i's result
//   fu_complete   out  per-lane finished results
//   idle          out  every stage of every lane is empty
module mult_fu_bank
  import mult_fu_bank_pkg::*;
#(
  parameter int MULT_STAGES = MULT_STAGES_DEFAULT,
  parameter int NUM_LANES   = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                squash,
  input  ISSUE_FU_PACKET    [NUM_LANES-1:0]   fu_pckt_in,
  output logic              [NUM_LANES-1:0]   rd_EN,
  input  logic              [NUM_LANES-1:0]   complete_gnt,
  output FU_COMPLETE_PACKET [NUM_LANES-1:0]   fu_complete,
  output logic                                idle
);

  logic [NUM_LANES-1:0] advance;
  logic [NUM_LANES-1:0] lane_empty;

  // A lane moves when its output slot is free or is being taken this cycle.
  // rd_EN depends only on lane state, grants, squash and reset, never on
  // fu_pckt_in, because the FIFO output is combinational from rd_EN.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      advance[i] = !fu_complete[i].valid || complete_gnt[i];
    end
    rd_EN = advance & {NUM_LANES{!squash && !reset}};
    idle  = &lane_empty;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mult_lane #(
      .MULT_STAGES(MULT_STAGES)
    ) u_lane (
      .clock       (clock),
      .reset       (reset),
      .squash      (squash),
      .pckt_in     (fu_pckt_in[i]),
      .advance     (advance[i]),
      .complete_out(fu_complete[i]),
      .lane_empty  (lane_empty[i])
    );
  end

endmodule

// File: tb/tb_mult_fu_bank.sv
// Self-checking bench for mult_fu_bank. A queue-per-lane model computes
// results with plain 64-bit arithmetic and tracks pipeline position per op.
// A compare process checks every output on every cycle after reset.
module tb_mult_fu_bank;
  import mult_fu_bank_pkg::*;

  localparam int STAGES = 4;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        squash;
  ISSUE_FU_PACKET    [2:0]     fu_pckt_in;
  logic              [2:0]     rd_EN;
  logic              [2:0]     complete_gnt;
  FU_COMPLETE_PACKET [2:0]     fu_complete;
  logic                        idle;

  int checks_total  = 0;
  int checks_passed = 0;
  bit check_en      = 1'b0;
  bit count_en      = 1'b0;
  logic [5:0] seen_dest [$];

  typedef struct {
    logic [31:0] res;
    logic [5:0]  dest;
    logic [4:0]  rob;
    int          pos;
  } model_entry_t;

  model_entry_t model_q [3][$];

  mult_fu_bank #(
    .MULT_STAGES(STAGES),
    .NUM_LANES  (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .fu_pckt_in  (fu_pckt_in),
    .rd_EN       (rd_EN),
    .complete_gnt(complete_gnt),
    .fu_complete (fu_complete),
    .idle        (idle)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [31:0] model_result(input MULT_OP op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULH:    p = sa * sb;
      MULHSU:  p = sa * longint'({32'b0, b});
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic ISSUE_FU_PACKET make_pkt(input MULT_OP op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [5:0] d,
                                              input logic [4:0] r);
    ISSUE_FU_PACKET p;
    p.valid     = 1'b1;
    p.op_sel    = op;
    p.rs1_value = a;
    p.rs2_value = b;
    p.dest_pr   = d;
    p.rob_entry = r;
    return p;
  endfunction

  function automatic ISSUE_FU_PACKET seq_pkt(input int k);
    return make_pkt(MULT_OP'(k % 4), 32'h9000_0001 + 32'(k * 7),
                    32'h0000_0100 * 32'(k + 1) + 32'(k), 6'(k + 10), 5'(k + 1));
  endfunction

  function automatic bit model_last_valid(input int l);
    return (model_q[l].size() > 0) && (model_q[l][0].pos == STAGES - 1);
  endfunction

  task automatic compare_all();
    bit any_busy;
    any_busy = 1'b0;
    for (int l = 0; l < 3; l++) begin
      bit lv;
      lv = model_last_valid(l);
      if (model_q[l].size() > 0) any_busy = 1'b1;
      if (lv) begin
        check_output($sformatf("valid[%0d]", l), 64'(fu_complete[l].valid), 64'd1);
        check_output($sformatf("result[%0d]", l), 64'(fu_complete[l].result),
                     64'(model_q[l][0].res));
        check_output($sformatf("dest_pr[%0d]", l), 64'(fu_complete[l].dest_pr),
                     64'(model_q[l][0].dest));
        check_output($sformatf("rob_entry[%0d]", l), 64'(fu_complete[l].rob_entry),
                     64'(model_q[l][0].rob));
      end else begin
        check_output($sformatf("empty_out[%0d]", l), 64'(fu_complete[l]), 64'd0);
      end
      check_output($sformatf("rd_EN[%0d]", l), 64'(rd_EN[l]),
                   64'((!lv || complete_gnt[l]) && !squash && !reset));
    end
    check_output("idle", 64'(idle), 64'(!any_busy));
  endtask

  task automatic model_update();
    for (int l = 0; l < 3; l++) begin
      if (reset || squash) begin
        model_q[l].delete();
      end else if (!model_last_valid(l) || complete_gnt[l]) begin
        model_entry_t e;
        if (model_last_valid(l)) void'(model_q[l].pop_front());
        for (int j = 0; j < model_q[l].size(); j++) model_q[l][j].pos++;
        if (fu_pckt_in[l].valid) begin
          e.res  = model_result(fu_pckt_in[l].op_sel, fu_pckt_in[l].rs1_value,
                                fu_pckt_in[l].rs2_value);
          e.dest = fu_pckt_in[l].dest_pr;
          e.rob  = fu_pckt_in[l].rob_entry;
          e.pos  = 0;
          model_q[l].push_back(e);
        end
      end
    end
  endtask

  // Compare at negedge, advance the model on the posedge that follows.
  initial begin
    forever begin
      @(negedge clock);
      if (check_en) compare_all();
      @(posedge clock);
      model_update();
    end
  end

  // Records lane 0 handshakes to verify ordering and count under stall.
  always @(posedge clock) begin
    if (count_en && !reset && !squash && fu_complete[0].valid && complete_gnt[0])
      seen_dest.push_back(fu_complete[0].dest_pr);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus();
    FU_COMPLETE_PACKET held;

    check_output("model_mul",    64'(model_result(MUL,    32'd7,        32'hFFFFFFFD)), 64'hFFFFFFEB);
    check_output("model_mulhu",  64'(model_result(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFE);
    check_output("model_mulh",   64'(model_result(MULH,   32'h80000000, 32'h80000000)), 64'h40000000);
    check_output("model_mulhsu", 64'(model_result(MULHSU, 32'hFFFFFFFF, 32'd2)),        64'hFFFFFFFF);

    reset        = 1'b1;
    squash       = 1'b0;
    complete_gnt = 3'b111;
    fu_pckt_in   = '0;
    step();
    step();
    reset    = 1'b0;
    check_en = 1'b1;
    @(negedge clock);
    check_output("reset_out",   64'(fu_complete), 64'd0);
    check_output("reset_idle",  64'(idle),        64'd1);
    check_output("reset_rd_EN", 64'(rd_EN),       64'b111);
    step();

    fu_pckt_in[0] = make_pkt(MUL, 32'd7, 32'hFFFFFFFD, 6'd5, 5'd9);
    step();
    fu_pckt_in = '0;
    step();
    step();
    @(negedge clock);
    check_output("mul_early_valid", 64'(fu_complete[0].valid), 64'd0);
    step();
    @(negedge clock);
    check_output("mul_valid",  64'(fu_complete[0].valid),     64'd1);
    check_output("mul_result", 64'(fu_complete[0].result),    64'hFFFFFFEB);
    check_output("mul_dest",   64'(fu_complete[0].dest_pr),   64'd5);
    check_output("mul_rob",    64'(fu_complete[0].rob_entry), 64'd9);
    step();

    fu_pckt_in[0] = make_pkt(MULHSU, 32'hFFFFFFFF, 32'd2,        6'd1, 5'd1);
    fu_pckt_in[1] = make_pkt(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 5'd2);
    fu_pckt_in[2] = make_pkt(MULH,   32'h80000000, 32'h80000000, 6'd3, 5'd3);
    step();
    fu_pckt_in = '0;
    repeat (3) step();
    @(negedge clock);
    check_output("mulhsu_result", 64'(fu_complete[0].result), 64'hFFFFFFFF);
    check_output("mulhu_result",  64'(fu_complete[1].result), 64'hFFFFFFFE);
    check_output("mulh_result",   64'(fu_complete[2].result), 64'h40000000);
    step();

    seen_dest.delete();
    count_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fu_pckt_in[0] = seq_pkt(k);
      if (k == 4) begin
        complete_gnt[0] = 1'b0;
        @(negedge clock);
        held = fu_complete[0];
        check_output("stall_head_dest", 64'(held.dest_pr), 64'd10);
        for (int c = 0; c < 3; c++) begin
          @(negedge clock);
          check_output("stall_rd_EN", 64'(rd_EN[0]), 64'd0);
          check_output("stall_stable", 64'(fu_complete[0]), 64'(held));
          step();
        end
        complete_gnt[0] = 1'b1;
      end
      step();
    end
    fu_pckt_in = '0;
    repeat (8) step();
    count_en = 1'b0;
    check_output("stream_count", 64'(seen_dest.size()), 64'd6);
    for (int k = 0; k < 6 && k < seen_dest.size(); k++) begin
      check_output($sformatf("stream_order[%0d]", k), 64'(seen_dest[k]), 64'(k + 10));
    end

    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 3; l++) fu_pckt_in[l] = seq_pkt(k + l);
      step();
    end
    squash = 1'b1;
    @(negedge clock);
    check_output("squash_rd_EN", 64'(rd_EN), 64'd0);
    step();
    squash     = 1'b0;
    fu_pckt_in = '0;
    @(negedge clock);
    check_output("squash_idle", 64'(idle), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check_output("squash_no_valid",
                   64'({fu_complete[2].valid, fu_complete[1].valid, fu_complete[0].valid}), 64'd0);
      step();
    end

    complete_gnt = 3'b101;
    for (int k = 0; k < 4; k++) begin
      fu_pckt_in[1] = seq_pkt(k + 20);
      step();
    end
    fu_pckt_in[1]   = seq_pkt(30);
    complete_gnt[1] = 1'b1;
    @(negedge clock);
    check_output("gc_rd_EN", 64'(rd_EN[1]), 64'd1);
    check_output("gc_head_dest", 64'(fu_complete[1].dest_pr), 64'(6'(20 + 10)));
    step();
    fu_pckt_in      = '0;
    complete_gnt[1] = 1'b0;
    @(negedge clock);
    check_output("gc_next_valid", 64'(fu_complete[1].valid), 64'd1);
    check_output("gc_next_result", 64'(fu_complete[1].result),
                 64'(model_result(MULT_OP'(21 % 4), 32'h9000_0001 + 32'(21 * 7),
                                  32'h0000_0100 * 32'(22) + 32'(21))));
    check_output("gc_next_dest", 64'(fu_complete[1].dest_pr), 64'd31);
    step();
    complete_gnt = 3'b111;
    repeat (8) step();
    @(negedge clock);
    check_output("final_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    apply_stimulus();
    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
